// File: rtl/adder_chunked_seq_if.sv
// Request/response bundle for the chunked adder: operands and start in,
// busy/done handshake plus result, carry and signed overflow out.
interface adder_chunked_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    modport master (
        output start, op, a, b, carryin,
        input  busy, done, sum, carryout, overflow
    );

    modport slave (
        input  start, op, a, b, carryin,
        output busy, done, sum, carryout, overflow
    );
endinterface

// File: rtl/adder_chunked_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice walks the operands
// LSB-first, with the inter-chunk carry held in a register.
module adder_chunked_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_chunked_seq_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             busy_q;
    logic             done_q;
    logic             carryout_q;
    logic             overflow_q;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_res_s;
    logic             chunk_cout_s;
    logic             msb_cin_s;
    logic [WIDTH-1:0] sum_d;

    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             cin
    );
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Ripple slice for the current chunk; the MSB carry-in is recovered from the
    // slice's own sum bit so overflow does not depend on the registered carry.
    always_comb begin
        a_chunk_s    = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk_s    = b_q[idx_q*CHUNK +: CHUNK];
        chunk_res_s  = chunk_add(a_chunk_s, b_chunk_s, carry_q);
        chunk_cout_s = chunk_res_s[CHUNK];
        msb_cin_s    = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ chunk_res_s[CHUNK-1];
        sum_d        = sum_q;
        sum_d[idx_q*CHUNK +: CHUNK] = chunk_res_s[CHUNK-1:0];
    end

    // Control FSM and datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.op ? ~bus.b : bus.b;
                        carry_q <= bus.carryin ^ bus.op;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= chunk_cout_s;
                    if (idx_q == LAST_IDX) begin
                        idx_q      <= '0;
                        carryout_q <= chunk_cout_s;
                        overflow_q <= msb_cin_s ^ chunk_cout_s;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.carryout = carryout_q;
    assign bus.overflow = overflow_q;
endmodule

// File: doc/adder_chunked_seq.md
Name: adder_chunked_seq

Overview:
- Parametrised multi-cycle adder/subtractor.
- Processes WIDTH-bit operands CHUNK bits per clock through one CHUNK-bit ripple slice, keeping a registered carry between chunks.
- Successor to the fixed 4-bit ripple adder: adds generic width, a subtract mode, signed overflow, and a start/busy/done handshake.
- Used where wide adds are needed and area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle. The number of chunks is NCH = WIDTH/CHUNK, and NCH must be at least 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- start  input  1  request a new operation; sampled only when busy=0
- op  input  1  0 = add, 1 = subtract
- a  input  WIDTH  operand A, latched on accept
- b  input  WIDTH  operand B, latched on accept
- carryin  input  1  carry-in, latched on accept
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result, held until the next accept
- carryout  output  1  final carry out of the MSB chunk
- overflow  output  1  signed (two's complement) overflow

Behaviour:
- Clocking and reset:
  - Single clock domain, rising edge. Reset is synchronous, active low.
  - While rst_n=0 at an edge: busy, done, sum, carryout, overflow, chunk index, carry register and operand registers all go to 0. State goes to IDLE.
- IDLE state (busy=0):
  - At an edge with start=1, the operation is accepted.
  - Latch a into A_r.
  - Latch B_r = op ? ~b : b.
  - Carry register gets carryin ^ op. With op=1 and carryin=0 the result is a - b; carryin=1 gives a - b - 1.
  - Set chunk index = 0, busy = 1, done = 0, state = RUN.
  - sum, carryout and overflow keep their previous values until the new result is written.
- RUN state (busy=1): each edge processes chunk i = index.
  - Bits [i*CHUNK +: CHUNK] of sum get A_r chunk + B_r chunk + carry register.
  - Carry register gets the chunk carry-out.
  - Index increments.
  - On the last chunk (index = NCH-1), also:
    - carryout = chunk carry-out.
    - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. This must be computed inside the last chunk, not from the registered carry.
    - busy = 0, done = 1, state = IDLE.
- Latency:
  - done is high in the cycle after edge E0+NCH, where E0 is the accept edge.
  - WIDTH=16, CHUNK=4 gives 4 cycles. NCH=1 gives 1 cycle.
- done:
  - Exactly one cycle wide. It deasserts at the next edge unless it is reset to 0 first.
- start while busy=1: ignored. It has no effect on operands, state or outputs. start is not queued.
- start in the done cycle: accepted, because busy=0. done drops at that edge and the new operation begins. This allows back-to-back operations at one per NCH+1 cycles from accept to accept.
- Input stability: a, b, op and carryin are don't-care after the accept edge.
- Reset mid-operation: the operation is aborted, done is never asserted for it, and all outputs read 0 the cycle after.
- Arithmetic:
  - Unsigned result modulo 2^WIDTH.
  - carryout=1 in subtract mode means no borrow.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Add carry chain: a=0xFFFF, b=0x0001, op=0, cin=0, start for one cycle → busy for 4 cycles, done 4 cycles after accept, sum=0x0000, carryout=1, overflow=0.
- Signed overflow: a=0x7FFF, b=0x0001, op=0 → sum=0x8000, carryout=0, overflow=1. Then a=0x8000, b=0xFFFF → sum=0x7FFF, carryout=1, overflow=1.
- Subtract: a=0x0005, b=0x0007, op=1, cin=0 → sum=0xFFFE, carryout=0, overflow=0. Then a=0x1234, b=0x0234 → sum=0x1000, carryout=1.
- Handshake:
  - Pulse start with a=0x0001, b=0x0001 while busy, 2 cycles after a first op of 0x0010+0x0020 was accepted → a single done, sum=0x0030. The second request is lost.
  - Re-issue start exactly in the done cycle → accepted; the next done arrives 4 cycles later with sum=0x0002.
- Reset: assert rst_n=0 for 1 cycle at chunk index 2 of 0xFFFF+0x0001 → busy=0, done never pulses, sum=0, carryout=0. The next op, 0x0003+0x0004, yields 0x0007.
- Parameter sweep:
  - WIDTH=8, CHUNK=8: done 1 cycle after accept for 0xFF+0x01, cin=1 → sum=0x01, carryout=1.
  - WIDTH=32, CHUNK=8: random vectors checked against a reference model, latency 4.
